sha256_msg_schedule: RTL and testbench
======================================

Name: sha256_msg_schedule

Overview:
Consumes the 512-bit big-endian block produced by the endian-swap stage (data_to_be) and expands it into the 64-word SHA-256 message schedule W[0..63]. It emits one 32-bit word per accepted handshake to the downstream compression-round stage. A 16-word sliding window generates each word on the fly, so the full 64-word schedule is never stored.

Parameters:
NUM_WORDS, 64, number of schedule words emitted per block; legal range 16..64.

Ports:
clk  input  1  system clock, all logic on the rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  request to load a new block; accepted only when busy=0
block_be  input  512  big-endian block from data_to_be; word k = block_be[32k+31:32k], k=0..15
busy  output  1  high from the cycle after start is accepted until done pulses
w_valid  output  1  w_data/w_idx hold a valid schedule word
w_ready  input  1  downstream accepts the word when w_valid&&w_ready
w_data  output  32  schedule word W[w_idx]
w_idx  output  6  index t of the current word, 0..NUM_WORDS-1
done  output  1  one-cycle pulse after the last word is accepted

Behaviour:
- Reset (reset_n=0, asynchronous): busy=0, w_valid=0, w_data=0, w_idx=0, done=0, window cleared, FSM=IDLE. The same applies mid-block: the block is abandoned and no done pulse is generated.
- FSM states are IDLE, EMIT, FIN.
- IDLE: when start=1, latch block_be words 0..15 into window slots 0..15. Next state is EMIT with w_valid=1, w_idx=0, w_data=word0, busy=1. start is ignored while busy=1.
- Latency: start accepted at cycle N gives the first valid word at cycle N+1.
- EMIT: w_data, w_idx and w_valid hold stable while w_valid&&!w_ready.
- On a handshake with w_idx < NUM_WORDS-1:
  - w_idx increments.
  - For the next t < 16, w_data = window word t.
  - For t >= 16, w_data = σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16], mod 2^32, with carries discarded.
  - σ0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
  - σ1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
  - Once t >= 16, the window shifts by one per handshake so it always holds W[t-16..t-1].
- Throughput: one word per cycle under continuous w_ready=1, so NUM_WORDS consecutive valid cycles.
- On a handshake with w_idx = NUM_WORDS-1: next state FIN, w_valid=0.
- FIN: done=1 for exactly one cycle. Then busy=0, state IDLE, w_idx=0.
  - start is accepted in IDLE from the following cycle.
  - Minimum block-to-block gap is 2 idle cycles.
- w_ready is ignored when w_valid=0. A start asserted in FIN is ignored.
- w_data while w_valid=0 retains its last value; it is don't-care to consumers.
- The generator must not use combinational loops. The single-cycle adder chain is a 4-operand 32-bit add; an optional internal pre-add register is allowed only if the external timing above is unchanged.

Test Plan:
1. Reset then idle: hold reset_n=0 for 3 cycles, release, hold start=0 for 10 cycles -> busy=0, w_valid=0, done=0, w_idx=0 throughout.
2. "abc" padded block: word0=0x61626380, words1..14=0, word15=0x00000018, w_ready=1 -> W0=0x61626380, W15=0x00000018, W16=0x61626380, W17=0x000F0000. All 64 words match the software model, done pulses at cycle N+65, and busy drops.
3. Backpressure: repeat test 2 with w_ready random at 50% plus a 7-cycle stall at w_idx=20 -> w_data/w_idx stable during stalls, identical word sequence, exactly 64 handshakes, one done pulse.
4. Start while busy: assert start with a different block at w_idx=5 -> ignored; the sequence still matches the original block.
5. Reset mid-block: drop reset_n at w_idx=30 -> w_valid=0 and busy=0 immediately (asynchronous), no done pulse. A new start afterwards emits W0 of the new block at N+1.
6. Back-to-back with carry wrap: block of all words 0xFFFFFFFF, then block of all zeros started on the first legal cycle after done -> modular sums match the model (no carry out), and the second block yields all-zero W[0..63].

Source files
------------

// File: rtl/sha256_msg_schedule_if.sv
// Handshake bundle between the block loader, the schedule generator and the round stage.
// Latency: none (wires only).
// Backpressure: w_ready from the consumer stalls the word stream; start is only taken while idle.
//
// Signals: start/block_be (block load request), busy/done (block status),
//          w_valid/w_ready/w_data/w_idx (schedule word stream).
interface sha256_msg_schedule_if;
    logic         start;
    logic [511:0] block_be;
    logic         busy;
    logic         w_valid;
    logic         w_ready;
    logic [31:0]  w_data;
    logic [5:0]   w_idx;
    logic         done;

    // master: the side that supplies blocks and consumes words
    modport master (
        output start, block_be, w_ready,
        input  busy, w_valid, w_data, w_idx, done
    );

    // slave: the schedule generator
    modport slave (
        input  start, block_be, w_ready,
        output busy, w_valid, w_data, w_idx, done
    );
endinterface

// File: rtl/sha256_msg_schedule.sv
// Expands one 512-bit big-endian block into the SHA-256 schedule W[0..NUM_WORDS-1], one word per handshake.
// Latency: first word valid the cycle after start is accepted; one word per cycle under w_ready=1.
// Backpressure: w_valid/w_data/w_idx hold while w_ready=0; start is ignored while busy.
//
// Ports: clk, reset_n (async active-low); bus (slave modport) carries start, block_be,
//        busy, w_valid, w_ready, w_data, w_idx, done.
module sha256_msg_schedule #(
    parameter int NUM_WORDS = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    sha256_msg_schedule_if.slave bus
);

    localparam logic [5:0] IDX_LAST = 6'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  w_idx_q, w_idx_d;
    logic [31:0] w_data_q, w_data_d;
    // win_q[i] holds W[t-16+i] once t >= 16; before that it holds the raw block words.
    logic [31:0] win_q [16];
    logic [31:0] win_d [16];

    logic        load;
    logic        hs;
    logic        last;
    logic [5:0]  next_t;
    logic [31:0] new_word;

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    assign load     = (state_q == IDLE) && bus.start;
    assign hs       = (state_q == EMIT) && bus.w_ready;
    assign last     = (w_idx_q == IDX_LAST);
    assign next_t   = w_idx_q + 6'd1;
    // Window taps: W[t-2]=slot 14, W[t-7]=slot 9, W[t-15]=slot 1, W[t-16]=slot 0.
    assign new_word = ssig1(win_q[14]) + win_q[9] + ssig0(win_q[1]) + win_q[0];

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            w_idx_q  <= '0;
            w_data_q <= '0;
            for (int i = 0; i < 16; i++) win_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            w_idx_q  <= w_idx_d;
            w_data_q <= w_data_d;
            for (int i = 0; i < 16; i++) win_q[i] <= win_d[i];
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = EMIT;
            EMIT:    if (hs && last) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: window load/shift and word generation
    always_comb begin
        w_idx_d  = w_idx_q;
        w_data_d = w_data_q;
        for (int i = 0; i < 16; i++) win_d[i] = win_q[i];

        if (load) begin
            for (int i = 0; i < 16; i++) win_d[i] = bus.block_be[32*i +: 32];
            w_idx_d  = '0;
            w_data_d = bus.block_be[31:0];
        end else if (hs && !last) begin
            w_idx_d = next_t;
            if (next_t < 6'd16) begin
                // Still replaying the block: the window is untouched until t reaches 16.
                w_data_d = win_q[next_t[3:0]];
            end else begin
                w_data_d = new_word;
                for (int i = 0; i < 15; i++) win_d[i] = win_q[i+1];
                win_d[15] = new_word;
            end
        end else if (state_q == FIN) begin
            w_idx_d = '0;
        end
    end

    // Outputs
    always_comb begin
        bus.busy    = (state_q != IDLE);
        bus.w_valid = (state_q == EMIT);
        bus.done    = (state_q == FIN);
        bus.w_data  = w_data_q;
        bus.w_idx   = w_idx_q;
    end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
module tb_sha256_msg_schedule;

    logic clk = 1'b0;
    logic reset_n;

    sha256_msg_schedule_if bus ();

    sha256_msg_schedule #(.NUM_WORDS(64)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef logic [31:0] sched_t [64];
    typedef struct {
        logic [5:0]  idx;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          hs_cnt   = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          start_cyc = 0;
    logic [31:0] got_w [64];
    bit          rand_mode = 0;
    bit          stall_arm = 0;
    int          stall_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: full schedule array straight from the SHA-256 recurrence.
    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic sched_t ref_schedule(input logic [511:0] blk);
        sched_t      w;
        logic [31:0] s0, s1;
        for (int t = 0; t < 16; t++) w[t] = blk[32*t +: 32];
        for (int t = 16; t < 64; t++) begin
            s0   = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1   = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = s1 + w[t-7] + s0 + w[t-16];
        end
        return w;
    endfunction

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int k = 0; k < 16; k++) b[32*k +: 32] = $urandom;
        return b;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Ready driver: always-ready, random, and a one-shot 7-cycle stall at w_idx=20.
    initial begin
        bus.w_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_cnt > 0) begin
                bus.w_ready = 1'b0;
                stall_cnt--;
            end else if (stall_arm && bus.w_valid && bus.w_idx == 6'd20) begin
                stall_arm   = 0;
                stall_cnt   = 6;
                bus.w_ready = 1'b0;
            end else begin
                bus.w_ready = rand_mode ? 1'($urandom % 2) : 1'b1;
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        logic        prev_stall;
        logic [31:0] pd;
        logic [5:0]  pi;
        exp_t        e;
        prev_stall = 1'b0;
        pd = '0;
        pi = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_stall = 1'b0;
                continue;
            end
            if (prev_stall && bus.w_valid) begin
                check("stall_data", bus.w_data, pd);
                check("stall_idx", 32'(bus.w_idx), 32'(pi));
            end
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (bus.w_valid && bus.w_ready) begin
                hs_cnt++;
                got_w[bus.w_idx] = bus.w_data;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_word: idx %0d data %h but nothing expected", bus.w_idx, bus.w_data);
                end else begin
                    e = exp_q.pop_front();
                    check("w_data", bus.w_data, e.data);
                    check("w_idx", 32'(bus.w_idx), 32'(e.idx));
                end
            end
            prev_stall = bus.w_valid && !bus.w_ready;
            pd = bus.w_data;
            pi = bus.w_idx;
        end
    end

    task automatic start_block(input logic [511:0] blk, input bit immediate);
        sched_t w;
        exp_t   e;
        int     k;
        if (!immediate) @(negedge clk);
        k = 0;
        while (bus.busy && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (k >= 300) check("start_wait_timeout", 32'(bus.busy), 32'd0);
        w = ref_schedule(blk);
        for (int t = 0; t < 64; t++) begin
            e.idx  = 6'(t);
            e.data = w[t];
            exp_q.push_back(e);
            got_w[t] = 32'hDEAD_BEEF;
        end
        hs_cnt       = 0;
        bus.block_be = blk;
        bus.start    = 1'b1;
        start_cyc    = cyc;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.block_be = rand_block();
        check("first_valid", 32'(bus.w_valid), 32'd1);
        check("first_idx", 32'(bus.w_idx), 32'd0);
        check("busy_after_start", 32'(bus.busy), 32'd1);
    endtask

    task automatic wait_done(input bit chk_lat);
        int d0;
        int k;
        d0 = done_cnt;
        k  = 0;
        while (done_cnt == d0 && k < 1000) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("done_pulses", 32'(done_cnt - d0), 32'd1);
        if (chk_lat) check("done_latency", 32'(done_cyc - start_cyc), 32'd65);
        check("handshakes", 32'(hs_cnt), 32'd64);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        check("post_done", 32'(bus.done), 32'd0);
        check("post_busy", 32'(bus.busy), 32'd0);
        check("post_valid", 32'(bus.w_valid), 32'd0);
        check("post_idx", 32'(bus.w_idx), 32'd0);
    endtask

    task automatic wait_idx(input logic [5:0] idx);
        int k;
        k = 0;
        while (!(bus.w_valid && bus.w_idx == idx) && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (k >= 300) check("wait_idx_timeout", 32'(bus.w_idx), 32'(idx));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [511:0] abc, blk_a, blk_b, ones, zeros;
        int d0;
        int nz;

        abc = '0;
        abc[31:0]    = 32'h6162_6380;
        abc[511:480] = 32'h0000_0018;
        ones  = '1;
        zeros = '0;

        // 1. reset then idle
        reset_n      = 1'b0;
        bus.start    = 1'b0;
        bus.block_be = '0;
        repeat (3) begin
            @(negedge clk);
            check("rst_w_data", bus.w_data, 32'd0);
            check("rst_busy", 32'(bus.busy), 32'd0);
        end
        reset_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("idle_busy", 32'(bus.busy), 32'd0);
            check("idle_valid", 32'(bus.w_valid), 32'd0);
            check("idle_done", 32'(bus.done), 32'd0);
            check("idle_idx", 32'(bus.w_idx), 32'd0);
        end

        // 2. "abc" block, always ready
        rand_mode = 0;
        start_block(abc, 0);
        wait_done(1);
        check("abc_w0", got_w[0], 32'h6162_6380);
        check("abc_w15", got_w[15], 32'h0000_0018);
        check("abc_w16", got_w[16], 32'h6162_6380);
        check("abc_w17", got_w[17], 32'h000F_0000);

        // 3. backpressure: random ready plus a long stall at w_idx=20
        rand_mode = 1;
        stall_arm = 1;
        start_block(abc, 0);
        wait_done(0);
        check("abc_bp_w17", got_w[17], 32'h000F_0000);
        rand_mode = 0;

        // 4. start while busy is ignored
        blk_a = rand_block();
        blk_b = rand_block();
        start_block(blk_a, 0);
        wait_idx(6'd5);
        bus.block_be = blk_b;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start    = 1'b0;
        wait_done(1);

        // 5. reset mid-block
        start_block(rand_block(), 0);
        wait_idx(6'd30);
        #1;
        reset_n = 1'b0;
        #1;
        check("arst_valid", 32'(bus.w_valid), 32'd0);
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_done", 32'(bus.done), 32'd0);
        exp_q.delete();
        d0 = done_cnt;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("arst_no_done", 32'(done_cnt), 32'(d0));
        start_block(rand_block(), 0);
        wait_done(1);

        // 6. back-to-back: all-ones block then all-zeros on the first legal cycle
        start_block(ones, 0);
        wait_done(1);
        start_block(zeros, 1);
        wait_done(1);
        nz = 0;
        for (int t = 0; t < 64; t++) if (got_w[t] != 32'd0) nz++;
        check("zero_block_nonzero_words", 32'(nz), 32'd0);

        // Extra randomized blocks under random backpressure
        rand_mode = 1;
        repeat (3) begin
            start_block(rand_block(), 0);
            wait_done(0);
        end
        rand_mode = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
